param_lsu: RTL and testbench

PARAM_LSU -- requirements
Module: param_lsu

---
 rtl/decoder_pkg.sv | 30 +++
 rtl/param_lsu_if.sv | 18 +
 rtl/param_lsu_lane_align.sv | 46 ++++
 rtl/param_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_param_lsu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared decode constants for the load/store path: LDST_* size codes, LSU FSM states
// and the size-code to byte-count decoder.
package decoder_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_D  = 3'b011;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Zero marks an unknown size code; width limits are applied by the LSU.
    function automatic logic [3:0] ldst_bytes(input logic [2:0] size);
        case (size)
            LDST_B, LDST_BU: ldst_bytes = 4'd1;
            LDST_H, LDST_HU: ldst_bytes = 4'd2;
            LDST_W:          ldst_bytes = 4'd4;
            LDST_D:          ldst_bytes = 4'd8;
            default:         ldst_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/param_lsu_if.sv
// Memory-side beat bus of the LSU: one request per beat, completed by mem_ready.
interface param_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;
    logic                  mem_ready;

    modport master (output mem_req, mem_we, mem_be, mem_addr, mem_wd,
                    input  mem_rd, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_be, mem_addr, mem_wd,
                    output mem_rd, mem_ready);
endinterface

// File: rtl/param_lsu_lane_align.sv
// Combinational byte-lane steering: store lane shift across two beats, load merge of
// two beats and sign/zero extension of the selected bytes.
module lsu_lane_align
    import decoder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  logic [2:0]                  size_i,
    input  logic [DATA_W-1:0]           wd_i,
    input  logic [DATA_W-1:0]           rd_lo_i,
    input  logic [DATA_W-1:0]           rd_hi_i,
    output logic [2*(DATA_W/8)-1:0]     be_o,
    output logic [2*DATA_W-1:0]         wd_o,
    output logic [DATA_W-1:0]           rd_o
);
    localparam int MW = 2 * (DATA_W / 8);

    logic [3:0]          nbytes;
    logic [MW-1:0]       mask;
    logic [DATA_W-1:0]   raw;
    logic signed [7:0]   b_s;
    logic signed [15:0]  h_s;
    logic signed [31:0]  w_s;

    always_comb begin
        nbytes = ldst_bytes(size_i);
        mask   = MW'((17'd1 << nbytes) - 17'd1);
        be_o   = mask << off_i;
        wd_o   = {{DATA_W{1'b0}}, wd_i} << {off_i, 3'b000};
        // Upper beat supplies the bytes that spill past the top lane.
        raw    = DATA_W'({rd_hi_i, rd_lo_i} >> {off_i, 3'b000});
        b_s    = raw[7:0];
        h_s    = raw[15:0];
        w_s    = raw[31:0];
        case (size_i)
            LDST_B:  rd_o = DATA_W'(b_s);
            LDST_H:  rd_o = DATA_W'(h_s);
            LDST_W:  rd_o = DATA_W'(w_s);
            LDST_BU: rd_o = DATA_W'(raw[7:0]);
            LDST_HU: rd_o = DATA_W'(raw[15:0]);
            LDST_D:  rd_o = raw;
            default: rd_o = '0;
        endcase
    end
endmodule

// File: rtl/param_lsu.sv
// Load/store unit: one core access becomes one (or two, when LSU_MISALIGN_SPLIT_EN is
// defined) memory beats; rejected accesses answer with core_err_o and no beat.
module param_lsu
    import decoder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [2:0]          core_size_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wd_i,
    output logic [DATA_W-1:0]   core_rd_o,
    output logic                core_stall_o,
    output logic                core_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wd_o,
    input  logic [DATA_W-1:0]   mem_rd_i,
    input  logic                mem_ready_i
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [2:0]          size_q, size_d;
    logic [OW-1:0]       off_q, off_d;

    logic [OW-1:0]       off_c, lane_off;
    logic [2:0]          lane_size;
    logic [3:0]          nbytes_c;
    logic [4:0]          end_c;
    logic                legal_c, misal_c;
    logic [2*NB-1:0]     be_w;
    logic [2*DATA_W-1:0] wd_w;
    logic [DATA_W-1:0]   rd_lo, rd_hi, rd_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic                split_q, split_d;
    logic [NB-1:0]       be_hi_q, be_hi_d;
    logic [DATA_W-1:0]   wd_hi_q, wd_hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    assign rd_lo = (state_q == BEAT1) ? lo_q : mem_rd_i;
    assign rd_hi = (state_q == BEAT1) ? mem_rd_i : '0;
`else
    logic unused_hi;

    assign unused_hi = ^{be_w[2*NB-1:NB], wd_w[2*DATA_W-1:DATA_W]};
    assign rd_lo     = mem_rd_i;
    assign rd_hi     = '0;
`endif

    assign off_c     = core_addr_i[OW-1:0];
    assign nbytes_c  = ldst_bytes(core_size_i);
    assign legal_c   = (nbytes_c != 4'd0) && (32'(nbytes_c) <= NB);
    assign end_c     = 5'(off_c) + 5'(nbytes_c);
    assign misal_c   = end_c > 5'(NB);
    assign lane_off  = (state_q == IDLE) ? off_c : off_q;
    assign lane_size = (state_q == IDLE) ? core_size_i : size_q;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .off_i   (lane_off),
        .size_i  (lane_size),
        .wd_i    (core_wd_i),
        .rd_lo_i (rd_lo),
        .rd_hi_i (rd_hi),
        .be_o    (be_w),
        .wd_o    (wd_w),
        .rd_o    (rd_ext)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
            be_hi_q <= '0;
            wd_hi_q <= '0;
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            err_q   <= err_d;
            size_q  <= size_d;
            off_q   <= off_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= split_d;
            be_hi_q <= be_hi_d;
            wd_hi_q <= wd_hi_d;
            lo_q    <= lo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        we_d    = we_q;
        err_d   = err_q;
        size_d  = size_q;
        off_d   = off_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d = split_q;
        be_hi_d = be_hi_q;
        wd_hi_d = wd_hi_q;
        lo_d    = lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    we_d    = core_we_i;
                    size_d  = core_size_i;
                    off_d   = off_c;
                    addr_d  = core_addr_i & ~ADDR_W'(NB - 1);
                    be_d    = be_w[NB-1:0];
                    wd_d    = wd_w[DATA_W-1:0];
                    rd_d    = '0;
                    state_d = BEAT0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d = misal_c;
                    be_hi_d = be_w[2*NB-1:NB];
                    wd_hi_d = wd_w[2*DATA_W-1:DATA_W];
                    if (!legal_c) begin
`else
                    if (!legal_c || misal_c) begin
`endif
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                    rd_d    = we_q ? '0 : rd_ext;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state_d = BEAT1;
                        rd_d    = rd_q;
                        lo_d    = mem_rd_i;
                        addr_d  = addr_q + ADDR_W'(NB);
                        be_d    = be_hi_q;
                        wd_d    = wd_hi_q;
                    end
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                    rd_d    = we_q ? '0 : rd_ext;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rd_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_o    = (state_q == BEAT0) || (state_q == BEAT1);
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;
    assign core_rd_o    = rd_q;
    assign core_err_o   = err_q;
    assign core_stall_o = core_req_i && (state_q != RESP);
endmodule

// File: tb/tb_param_lsu.sv
// Bench for param_lsu: vector table through a scoreboard on a 32-bit instance, plus
// reset-in-beat and 64-bit doubleword sequences.
module tb_param_lsu;
    import decoder_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, core_stall, core_err;
    logic [2:0]    core_size;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wd, core_rd;

    param_lsu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic          r64_req, r64_stall, r64_err, r64_mreq, r64_mwe, r64_ready;
    logic [2:0]    r64_size;
    logic [AW-1:0] r64_addr, r64_maddr;
    logic [63:0]   r64_wd, r64_rd, r64_mwd, r64_mrd;
    logic [7:0]    r64_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_lsu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
        .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
        .mem_req_o(bus.mem_req), .mem_we_o(bus.mem_we), .mem_be_o(bus.mem_be),
        .mem_addr_o(bus.mem_addr), .mem_wd_o(bus.mem_wd),
        .mem_rd_i(bus.mem_rd), .mem_ready_i(bus.mem_ready)
    );

    param_lsu #(.DATA_W(64), .ADDR_W(AW)) dut64 (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(r64_req), .core_we_i(1'b0), .core_size_i(r64_size),
        .core_addr_i(r64_addr), .core_wd_i(r64_wd),
        .core_rd_o(r64_rd), .core_stall_o(r64_stall), .core_err_o(r64_err),
        .mem_req_o(r64_mreq), .mem_we_o(r64_mwe), .mem_be_o(r64_be),
        .mem_addr_o(r64_maddr), .mem_wd_o(r64_mwd),
        .mem_rd_i(r64_mrd), .mem_ready_i(r64_ready)
    );

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr, wd, rd0, rd1;
        int          dly, nbeats;
        logic [31:0] a0, w0, a1, w1;
        logic [3:0]  be0, be1;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lmask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic add(input logic we, input logic [2:0] sz, input logic [31:0] addr, wd, rd0, rd1,
                       input int dly, nb, input logic [31:0] a0, input logic [3:0] be0,
                       input logic [31:0] w0, input logic [31:0] a1, input logic [3:0] be1,
                       input logic [31:0] w1, input logic [31:0] erd, input logic eerr, input int lat);
        vec_t v;
        v.we = we; v.size = sz; v.addr = addr; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1;
        v.dly = dly; v.nbeats = nb; v.a0 = a0; v.be0 = be0; v.w0 = w0;
        v.a1 = a1; v.be1 = be1; v.w1 = w1; v.exp_rd = erd; v.exp_err = eerr; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        vec_t e;
        int   cyc = 1;
        int   beat = 0;
        int   waitc = 0;
        bit   done = 0;
        sb.push_back(v);
        core_req = 1'b1; core_we = v.we; core_size = v.size;
        core_addr = v.addr; core_wd = v.wd; bus.mem_ready = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.mem_ready = 1'b0;
            if (!core_stall) begin
                e = sb.pop_front();
                chk($sformatf("v%0d rd", id), core_rd, e.exp_rd);
                chk($sformatf("v%0d err", id), core_err, e.exp_err);
                chk($sformatf("v%0d latency", id), cyc, e.lat);
                chk($sformatf("v%0d beats", id), beat, e.nbeats);
                chk($sformatf("v%0d resp req", id), bus.mem_req, 1'b0);
                done = 1;
            end else if (bus.mem_req) begin
                if (waitc == 0) begin
                    chk($sformatf("v%0d b%0d addr", id, beat), bus.mem_addr, (beat == 0) ? v.a0 : v.a1);
                    chk($sformatf("v%0d b%0d be", id, beat), bus.mem_be, (beat == 0) ? v.be0 : v.be1);
                    chk($sformatf("v%0d b%0d we", id, beat), bus.mem_we, v.we);
                    if (v.we)
                        chk($sformatf("v%0d b%0d wd", id, beat),
                            bus.mem_wd & lmask((beat == 0) ? v.be0 : v.be1), (beat == 0) ? v.w0 : v.w1);
                end
                bus.mem_rd = (beat == 0) ? v.rd0 : v.rd1;
                if (waitc >= v.dly) begin
                    bus.mem_ready = 1'b1;
                    beat++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
        end
        chk($sformatf("v%0d completed", id), done, 1'b1);
        core_req = 1'b0;
        bus.mem_ready = 1'b0;
        if (!done) begin
            void'(sb.pop_front());
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run64(input string nm, input logic [2:0] size, input logic [31:0] addr,
                         input logic [63:0] rd, input logic [7:0] be, input logic [31:0] maddr,
                         input logic [63:0] exp);
        bit done = 0;
        r64_req = 1'b1; r64_size = size; r64_addr = addr; r64_mrd = rd; r64_ready = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            r64_ready = 1'b0;
            if (!r64_stall) begin
                chk({nm, " rd"}, r64_rd, exp);
                chk({nm, " err"}, r64_err, 1'b0);
                done = 1;
            end else if (r64_mreq) begin
                chk({nm, " be"}, r64_be, be);
                chk({nm, " addr"}, r64_maddr, maddr);
                r64_ready = 1'b1;
            end
        end
        chk({nm, " completed"}, done, 1'b1);
        r64_req = 1'b0;
        r64_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = '0; core_addr = '0; core_wd = '0;
        bus.mem_rd = '0; bus.mem_ready = 1'b0;
        r64_req = 1'b0; r64_size = '0; r64_addr = '0; r64_wd = '0; r64_mrd = '0; r64_ready = 1'b0;

        //  we sz       addr   wd            rd0           rd1           dly nb a0     be0      w0            a1     be1      w1            exp_rd        err lat
        add(0, LDST_W,  'h100, 'h0,          'hDEADBEEF,   'h0,          0,  1, 'h100, 4'b1111, 'h0,          'h0,   4'b0000, 'h0,          'hDEADBEEF,   0,  3);
        add(0, LDST_B,  'h103, 'h0,          'h80123456,   'h0,          0,  1, 'h100, 4'b1000, 'h0,          'h0,   4'b0000, 'h0,          'hFFFFFF80,   0,  3);
        add(0, LDST_BU, 'h103, 'h0,          'h80123456,   'h0,          0,  1, 'h100, 4'b1000, 'h0,          'h0,   4'b0000, 'h0,          'h00000080,   0,  3);
        add(1, LDST_H,  'h102, 'h1234,       'h0,          'h0,          3,  1, 'h100, 4'b1100, 'h12340000,   'h0,   4'b0000, 'h0,          'h0,          0,  6);
        add(0, LDST_H,  'h102, 'h0,          'h8001ABCD,   'h0,          0,  1, 'h100, 4'b1100, 'h0,          'h0,   4'b0000, 'h0,          'hFFFF8001,   0,  3);
        add(0, LDST_HU, 'h100, 'h0,          'h1234F00D,   'h0,          2,  1, 'h100, 4'b0011, 'h0,          'h0,   4'b0000, 'h0,          'h0000F00D,   0,  5);
        add(1, LDST_B,  'h101, 'hFFFFFFAB,   'h0,          'h0,          0,  1, 'h100, 4'b0010, 'h0000AB00,   'h0,   4'b0000, 'h0,          'h0,          0,  3);
        add(1, LDST_W,  'h104, 'hCAFEF00D,   'h0,          'h0,          1,  1, 'h104, 4'b1111, 'hCAFEF00D,   'h0,   4'b0000, 'h0,          'h0,          0,  4);
        add(0, LDST_D,  'h100, 'h0,          'h11111111,   'h0,          0,  0, 'h0,   4'b0000, 'h0,          'h0,   4'b0000, 'h0,          'h0,          1,  2);
        add(1, 3'b111,  'h100, 'h55,         'h0,          'h0,          0,  0, 'h0,   4'b0000, 'h0,          'h0,   4'b0000, 'h0,          'h0,          1,  2);
`ifdef LSU_MISALIGN_SPLIT_EN
        add(0, LDST_W,  'h102, 'h0,          'h22115566,   'h77884433,   0,  2, 'h100, 4'b1100, 'h0,          'h104, 4'b0011, 'h0,          'h44332211,   0,  4);
        add(1, LDST_W,  'h103, 'h89ABCDEF,   'h0,          'h0,          0,  2, 'h100, 4'b1000, 'hEF000000,   'h104, 4'b0111, 'h0089ABCD,   'h0,          0,  4);
        add(0, LDST_H,  'h103, 'h0,          'hC1000000,   'h000000F2,   1,  2, 'h100, 4'b1000, 'h0,          'h104, 4'b0001, 'h0,          'hFFFFF2C1,   0,  6);
`else
        add(0, LDST_W,  'h102, 'h0,          'h22115566,   'h77884433,   0,  0, 'h0,   4'b0000, 'h0,          'h0,   4'b0000, 'h0,          'h0,          1,  2);
        add(1, LDST_W,  'h103, 'h89ABCDEF,   'h0,          'h0,          0,  0, 'h0,   4'b0000, 'h0,          'h0,   4'b0000, 'h0,          'h0,          1,  2);
        add(0, LDST_H,  'h103, 'h0,          'hC1000000,   'h000000F2,   1,  0, 'h0,   4'b0000, 'h0,          'h0,   4'b0000, 'h0,          'h0,          1,  2);
`endif

        repeat (2) @(negedge clk);
        chk("reset mem_req", bus.mem_req, 1'b0);
        chk("reset mem_we", bus.mem_we, 1'b0);
        chk("reset mem_be", bus.mem_be, 4'b0000);
        chk("reset mem_addr", bus.mem_addr, 32'h0);
        chk("reset mem_wd", bus.mem_wd, 32'h0);
        chk("reset core_rd", core_rd, 32'h0);
        chk("reset core_err", core_err, 1'b0);
        chk("reset stall", core_stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);
        chk("scoreboard drained", sb.size(), 0);

        // Reset while the first beat waits for ready, then a stray ready in IDLE.
        core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 'h200;
        bus.mem_rd = 'h5A5A1234; bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("rstbeat in beat0", bus.mem_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstbeat mem_req", bus.mem_req, 1'b0);
        chk("rstbeat mem_be", bus.mem_be, 4'b0000);
        chk("rstbeat mem_addr", bus.mem_addr, 32'h0);
        chk("rstbeat stall held", core_stall, 1'b1);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("reissue mem_req", bus.mem_req, 1'b1);
        chk("reissue addr", bus.mem_addr, 32'h200);
        @(negedge clk);
        chk("reissue stall", core_stall, 1'b0);
        chk("reissue rd", core_rd, 32'h5A5A1234);
        core_req = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);

        run64("d64 ld", LDST_D, 'h8, 64'h0123456789ABCDEF, 8'hFF, 'h8, 64'h0123456789ABCDEF);
        run64("d64 lw", LDST_W, 'hC, 64'h80000001_00000000, 8'hF0, 'h8, 64'hFFFFFFFF80000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
